// File: rtl/wb_modport_if.sv
// Wishbone classic signal bundle between the host adapter (master) and a
// 32-register slave block (5-bit word address).
interface wb_modport_if #(
  parameter int REG_WIDTH = 32
) ();
  logic [4:0]           wb_adr_o;
  logic [REG_WIDTH-1:0] wb_dat_o;
  logic [REG_WIDTH-1:0] wb_dat_i;
  logic [3:0]           sel_o;
  logic                 we_o;
  logic                 stb_o;
  logic                 cyc_o;
  logic                 ack_i;

  modport master (
    output wb_adr_o, wb_dat_o, sel_o, we_o, stb_o, cyc_o,
    input  wb_dat_i, ack_i
  );

  modport slave (
    input  wb_adr_o, wb_dat_o, sel_o, we_o, stb_o, cyc_o,
    output wb_dat_i, ack_i
  );
endinterface

// File: rtl/wb_modport.sv
// Host-to-Wishbone single-cycle adapter: turns one-shot host requests into
// classic Wishbone cycles, aborting with an error after TIMEOUT unacked clocks.
module wb_modport #(
  parameter int REG_WIDTH = 32,
  parameter int TIMEOUT   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 host_req,
  input  logic                 host_we,
  input  logic [4:0]           host_addr,
  input  logic [REG_WIDTH-1:0] host_wdata,
  input  logic [3:0]           host_sel,
  output logic                 host_ready,
  output logic                 host_done,
  output logic                 host_err,
  output logic [REG_WIDTH-1:0] host_rdata,
  wb_modport_if.master         wb
);

  typedef enum logic {IDLE, BUS} state_t;

  state_t               state_q;
  logic [7:0]           cnt_q;
  logic [7:0]           cnt_d;
  logic                 timeout_hit;
  logic [4:0]           adr_q;
  logic [REG_WIDTH-1:0] dat_q;
  logic [3:0]           sel_q;
  logic                 we_q;
  logic                 stb_q;
  logic                 cyc_q;
  logic                 ready_q;
  logic                 done_q;
  logic                 err_q;
  logic [REG_WIDTH-1:0] rdata_q;

  assign cnt_d       = cnt_q + 8'd1;
  // Counter starts at 0 on the first bus clock, so hitting TIMEOUT-1 means
  // cyc_o has been high for exactly TIMEOUT clocks.
  assign timeout_hit = (cnt_q == 8'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      stb_q   <= 1'b0;
      cyc_q   <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (host_req) begin
            adr_q   <= host_addr;
            dat_q   <= host_wdata;
            sel_q   <= host_sel;
            we_q    <= host_we;
            stb_q   <= 1'b1;
            cyc_q   <= 1'b1;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            state_q <= BUS;
          end
        end
        BUS: begin
          // Ack takes priority over a timeout landing on the same edge.
          if (wb.ack_i) begin
            if (!we_q) rdata_q <= wb.wb_dat_i;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b1;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end else if (timeout_hit) begin
            rdata_q <= '0;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign host_ready  = ready_q;
  assign host_done   = done_q;
  assign host_err    = err_q;
  assign host_rdata  = rdata_q;
  assign wb.wb_adr_o = adr_q;
  assign wb.wb_dat_o = dat_q;
  assign wb.sel_o    = sel_q;
  assign wb.we_o     = we_q;
  assign wb.stb_o    = stb_q;
  assign wb.cyc_o    = cyc_q;

endmodule

// File: tb/tb_wb_modport.sv
// Bench for wb_modport: directed steps plus randomized transactions checked
// against a transaction-level model of bus length, error and read data.
module tb_wb_modport;
  localparam int RW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          host_req;
  logic          host_we;
  logic [4:0]    host_addr;
  logic [RW-1:0] host_wdata;
  logic [3:0]    host_sel;
  logic          host_ready;
  logic          host_done;
  logic          host_err;
  logic [RW-1:0] host_rdata;

  wb_modport_if #(.REG_WIDTH(RW)) wb ();

  wb_modport #(.REG_WIDTH(RW), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_sel   (host_sel),
    .host_ready (host_ready),
    .host_done  (host_done),
    .host_err   (host_err),
    .host_rdata (host_rdata),
    .wb         (wb.master)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nfail = 0;
  logic [RW-1:0] model_rdata = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // One host transaction; the slave acks on bus clock waits+1 (never if waits >= TO).
  task automatic txn(input logic we, input logic [4:0] a, input logic [RW-1:0] d,
                     input logic [3:0] s, input int waits, input logic [RW-1:0] rd);
    int   len;
    int   exp_len;
    logic exp_err;
    bit   ended;
    exp_err = (waits >= TO);
    exp_len = exp_err ? TO : waits + 1;
    chk("ready_idle", host_ready, 1);
    host_req = 1; host_we = we; host_addr = a; host_wdata = d; host_sel = s;
    wb.ack_i = 0; wb.wb_dat_i = rd;
    step;
    host_req = 0; host_we = 1'($urandom); host_addr = 5'($urandom);
    host_wdata = $urandom; host_sel = 4'($urandom);
    chk("cyc_start", wb.cyc_o, 1);
    chk("stb_start", wb.stb_o, 1);
    chk("we_start", wb.we_o, we);
    chk("adr_start", wb.wb_adr_o, a);
    chk("dat_start", wb.wb_dat_o, d);
    chk("sel_start", wb.sel_o, s);
    chk("ready_bus", host_ready, 0);
    len = 0;
    ended = 0;
    for (int g = 0; g < 300 && !ended; g++) begin
      wb.ack_i = (len == waits);
      step;
      len++;
      if (!wb.cyc_o) ended = 1;
      else begin
        chk("done_mid", host_done, 0);
        chk("adr_hold", wb.wb_adr_o, a);
        chk("we_hold", wb.we_o, we);
        chk("rdata_hold", host_rdata, model_rdata);
      end
    end
    wb.ack_i = 0;
    chk("bus_end", 32'(ended), 1);
    chk("cyc_len", 32'(len), 32'(exp_len));
    chk("done_pulse", host_done, 1);
    chk("err", host_err, exp_err);
    chk("stb_end", wb.stb_o, 0);
    chk("we_end", wb.we_o, 0);
    if (exp_err) model_rdata = '0;
    else if (!we) model_rdata = rd;
    chk("rdata", host_rdata, model_rdata);
    chk("adr_kept", wb.wb_adr_o, a);
    chk("dat_kept", wb.wb_dat_o, d);
    chk("sel_kept", wb.sel_o, s);
    chk("ready_done", host_ready, 1);
    step;
    chk("done_clear", host_done, 0);
    chk("err_clear", host_err, 0);
  endtask

  initial begin
    rst = 1; host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0; host_sel = '0;
    wb.ack_i = 0; wb.wb_dat_i = '0;
    step; step;
    chk("rst_cyc", wb.cyc_o, 0);
    chk("rst_stb", wb.stb_o, 0);
    chk("rst_we", wb.we_o, 0);
    chk("rst_adr", wb.wb_adr_o, 0);
    chk("rst_dat", wb.wb_dat_o, 0);
    chk("rst_sel", wb.sel_o, 0);
    chk("rst_ready", host_ready, 1);
    chk("rst_done", host_done, 0);
    chk("rst_err", host_err, 0);
    chk("rst_rdata", host_rdata, 0);
    rst = 0;
    step;

    // Zero-wait write, 3-wait read, timeout, recovery read
    txn(1, 5'h0A, 32'hDEADBEEF, 4'hF, 0, 32'hAAAA5555);
    txn(0, 5'h1F, 32'h0, 4'hF, 3, 32'h12345678);
    txn(0, 5'h03, 32'h0, 4'h3, 1000, 32'hCAFEF00D);
    txn(0, 5'h04, 32'h0, 4'hF, 2, 32'h0BADC0DE);
    // Ack exactly on the timeout edge wins; one later is a timeout
    txn(0, 5'h05, 32'h0, 4'hF, TO - 1, 32'h55AA55AA);
    txn(0, 5'h06, 32'h0, 4'hF, TO, 32'h11112222);
    txn(0, 5'h07, 32'h0, 4'hF, 0, 32'h76543210);

    // Back-to-back with host_req held high
    host_req = 1; host_we = 1; host_addr = 5'd1; host_wdata = 32'h01010101; host_sel = 4'hF;
    wb.ack_i = 0;
    step;
    chk("b2b_cyc1", wb.cyc_o, 1);
    chk("b2b_adr1", wb.wb_adr_o, 1);
    host_addr = 5'd2; host_wdata = 32'h02020202; wb.ack_i = 1;
    step;
    wb.ack_i = 0;
    chk("b2b_gap_cyc", wb.cyc_o, 0);
    chk("b2b_done1", host_done, 1);
    step;
    chk("b2b_cyc2", wb.cyc_o, 1);
    chk("b2b_adr2", wb.wb_adr_o, 2);
    chk("b2b_dat2", wb.wb_dat_o, 32'h02020202);
    host_req = 0; wb.ack_i = 1;
    step;
    wb.ack_i = 0;
    chk("b2b_done2", host_done, 1);
    chk("b2b_err2", host_err, 0);
    chk("b2b_rdata", host_rdata, model_rdata);
    step;
    chk("b2b_done_clear", host_done, 0);

    // Reset on the second wait-state clock abandons the cycle
    host_req = 1; host_we = 0; host_addr = 5'h09; host_sel = 4'hF;
    step;
    host_req = 0;
    step;
    chk("mid_cyc_busy", wb.cyc_o, 1);
    rst = 1;
    step;
    rst = 0;
    model_rdata = '0;
    chk("mid_cyc", wb.cyc_o, 0);
    chk("mid_done", host_done, 0);
    chk("mid_ready", host_ready, 1);
    chk("mid_rdata", host_rdata, model_rdata);
    wb.ack_i = 1; wb.wb_dat_i = 32'hFFFFFFFF;
    step;
    wb.ack_i = 0;
    chk("idle_ack_done", host_done, 0);
    chk("idle_ack_cyc", wb.cyc_o, 0);
    chk("idle_ack_rdata", host_rdata, model_rdata);
    step;

    // Randomized transactions
    for (int i = 0; i < 24; i++) begin
      int w;
      w = ($urandom_range(0, 7) == 0) ? 1000 : int'($urandom_range(0, 20));
      txn(1'($urandom), 5'($urandom), $urandom, 4'($urandom), w, $urandom);
      if ($urandom_range(0, 1) == 1) step;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
